time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 1000, idle clk cycles in any SET state before abandoning the edit.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rstn  input  1  asynchronous, active-high reset; rstn=1 resets immediately, independent of clk.
REQ-004 Port: cur_time  input  20  live time from the time counter; packing [19:18] hour tens, [17:14] hour units, [13:11] minute tens, [10:7] minute units, [6:4] second tens, [3:0] second units, all BCD.
REQ-005 Port: btn_mode  input  1  single-cycle pulse; advances the edit state.
REQ-006 Port: btn_inc  input  1  single-cycle pulse; increments the selected field.
REQ-007 Port: btn_dec  input  1  single-cycle pulse; decrements the selected field.
REQ-008 Port: cnt_en  output  1  counter run enable; 1 in RUN, 0 in every SET state.
REQ-009 Port: load  output  1  one-cycle strobe; the counter loads load_time when it is 1.
REQ-010 Port: load_time  output  20  edited time, same packing as cur_time.
REQ-011 Port: edit_field  output  2  0=none, 1=hours, 2=minutes, 3=seconds.

Function
REQ-012 States: RUN, SET_H, SET_M, SET_S, COMMIT.
REQ-013 RUN + btn_mode -> SET_H; on the same edge, shadow register (drives load_time) <= cur_time.
REQ-014 SET_H + btn_mode -> SET_M; SET_M + btn_mode -> SET_S; SET_S + btn_mode -> COMMIT.
REQ-015 COMMIT lasts exactly one cycle with load=1, then -> RUN unconditionally; buttons in COMMIT are ignored.
REQ-016 load = 1 only in COMMIT; cnt_en = 1 only in RUN and COMMIT; edit_field = 1/2/3 in SET_H/SET_M/SET_S, otherwise 0; all outputs registered.
REQ-017 btn_inc/btn_dec in RUN are ignored.
REQ-018 Hours field: inc 23 -> 00, dec 00 -> 23; units roll 9 -> 0 with tens carry (09 -> 10, 19 -> 20); result is always valid BCD 00-23.
REQ-019 Minutes/seconds field: inc 59 -> 00, dec 00 -> 59, BCD carry/borrow (39 -> 40, 40 -> 39); no carry into any neighbouring field.
REQ-020 Only the selected field changes; the other two fields of the shadow hold their value.
REQ-021 btn_inc and btn_dec asserted in the same cycle: no change.
REQ-022 btn_mode with btn_inc or btn_dec in the same cycle: mode transition taken, inc/dec ignored.
REQ-023 Idle counter clears on entry to SET_H and on any button pulse; it increments every cycle in SET states without a button pulse.
REQ-024 Idle counter reaching TIMEOUT-1 in any SET state -> RUN with no load pulse; the shadow retains its value.
REQ-025 The shadow is updated only by REQ-013 and by inc/dec; cur_time changes while in SET states are ignored.

Reset
REQ-026 While rstn=1: state=RUN, cnt_en=1, load=0, load_time=20'h0, edit_field=0, idle counter=0.
REQ-027 Reset asserted mid-edit (any SET state or COMMIT) aborts at once: no load pulse is issued during or after reset.
REQ-028 After rstn falls, the first btn_mode pulse is honoured on the next rising clk edge.

Verification
REQ-029 cur_time=12:34:56, then btn_mode ×4 with no edits -> load one cycle with load_time=12:34:56, cnt_en low from the SET_H entry until COMMIT.
REQ-030 cur_time=23:59:59; SET_H inc -> 00; SET_M dec ×60 -> 59; SET_S inc -> 00 -> commit load_time=00:59:00.
REQ-031 Minutes 09: inc -> 10, dec -> 09; hours 20: dec -> 19; no invalid BCD nibble ever appears on load_time.
REQ-032 Same-cycle inc+dec in SET_M -> no change; same-cycle mode+inc in SET_H -> SET_M with hours unchanged.
REQ-033 TIMEOUT=16: enter SET_H, idle 16 cycles -> RUN, load never asserted, cnt_en returns to 1.
REQ-034 rstn pulsed high while in SET_S -> outputs at reset values immediately, no load pulse, RUN after release.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for an HH:MM:SS BCD time, loading the result into the time counter on commit.
module time_set_ctrl #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] cur_time,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    output logic        cnt_en,
    output logic        load,
    output logic [19:0] load_time,
    output logic [1:0]  edit_field
);
    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] SET_H  = 3'd1;
    localparam logic [2:0] SET_M  = 3'd2;
    localparam logic [2:0] SET_S  = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;
    localparam int IW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;

    logic [2:0]    r_state;
    logic [IW-1:0] r_idle;
    logic [19:0]   r_shadow;
    logic          r_cnt_en, r_load;
    logic [1:0]    r_edit;
    logic [2:0]    w_next;
    logic [19:0]   w_shadow;
    logic [7:0]    w_h, w_m, w_s;
    logic          w_set, w_btn, w_timeout, w_step;

    // Steps a two-digit BCD value by one, wrapping between 0 and mx; returns {tens, units}.
    function automatic logic [7:0] bcd_step(input logic [3:0] t, input logic [3:0] u,
                                            input logic [7:0] mx, input logic up);
        logic [7:0] b, n;
        b = 8'(t) * 8'd10 + 8'(u);
        n = up ? (b >= mx ? 8'd0 : b + 8'd1) : ((b == 8'd0 || b > mx) ? mx : b - 8'd1);
        return {4'(n / 8'd10), 4'(n % 8'd10)};
    endfunction

    assign w_set     = r_state == SET_H || r_state == SET_M || r_state == SET_S;
    assign w_btn     = btn_mode | btn_inc | btn_dec;
    assign w_timeout = w_set && !w_btn && r_idle == IW'(TIMEOUT - 1);
    assign w_step    = w_set && !btn_mode && (btn_inc ^ btn_dec);
    assign w_h = bcd_step({2'b0, r_shadow[19:18]}, r_shadow[17:14], 8'd23, btn_inc);
    assign w_m = bcd_step({1'b0, r_shadow[13:11]}, r_shadow[10:7], 8'd59, btn_inc);
    assign w_s = bcd_step({1'b0, r_shadow[6:4]}, r_shadow[3:0], 8'd59, btn_inc);

    always_comb begin
        w_next = r_state == RUN ? (btn_mode ? SET_H : RUN) :
                 !w_set         ? RUN :
                 w_timeout      ? RUN :
                 btn_mode       ? r_state + 3'd1 : r_state;
        w_shadow = (r_state == RUN && btn_mode) ? cur_time :
                   !w_step            ? r_shadow :
                   r_state == SET_H   ? {w_h[5:4], w_h[3:0], r_shadow[13:0]} :
                   r_state == SET_M   ? {r_shadow[19:14], w_m[6:4], w_m[3:0], r_shadow[6:0]} :
                                        {r_shadow[19:7], w_s[6:4], w_s[3:0]};
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state  <= RUN;
            r_idle   <= '0;
            r_shadow <= '0;
            r_cnt_en <= 1'b1;
            r_load   <= 1'b0;
            r_edit   <= 2'd0;
        end else begin
            r_state  <= w_next;
            r_idle   <= (w_set && !w_btn && !w_timeout) ? r_idle + IW'(1) : '0;
            r_shadow <= w_shadow;
            r_cnt_en <= w_next == RUN || w_next == COMMIT;
            r_load   <= w_next == COMMIT;
            r_edit   <= w_next[1:0];
        end
    end

    assign cnt_en     = r_cnt_en;
    assign load       = r_load;
    assign load_time  = r_shadow;
    assign edit_field = r_edit;
endmodule
